// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with optional two's complement input, overflow saturation and valid/ready.
`timescale 1ns/1ps
module seq_bin2bcd #(
   parameter int W_IN     = 8,
   parameter int N_DIGITS = 3,
   parameter int SIGNED   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W_IN-1:0]       in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*N_DIGITS-1:0] out_bcd,
   output logic                  out_neg,
   output logic                  out_overflow,
   output logic [1:0]            dbg_state
);

   localparam int                BW       = 4 * N_DIGITS;
   localparam int                CW       = $clog2(W_IN + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(W_IN);
   localparam logic [W_IN-1:0]   ONE      = W_IN'(1);
   localparam logic [BW-1:0]     ALL_NINE = {N_DIGITS{4'h9}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic            armed_q;
   logic [W_IN-1:0] bin_q, bin_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic            neg_q, neg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   res_bcd_q, res_bcd_d;
   logic            res_neg_q, res_neg_d;
   logic            res_ovf_q, res_ovf_d;

   logic            accept;
   logic            is_neg;
   logic [W_IN-1:0] mag;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   bcd_sh;
   logic [W_IN-1:0] bin_sh;
   logic            shift_out;

   // Handshakes: a word moves when valid and ready are both high at a rising
   // edge; the source holds valid/data until then, and ready never depends on valid.
   assign accept = in_valid & in_ready;
   assign is_neg = (SIGNED != 0) && in_data[W_IN-1];
   assign mag    = is_neg ? (~in_data + ONE) : in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CONV;
         S_CONV:  if (cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (state_q == S_IDLE) && armed_q;
      out_valid    = (state_q == S_DONE);
      out_bcd      = res_bcd_q;
      out_neg      = res_neg_q;
      out_overflow = res_ovf_q;
      dbg_state    = state_q;
   end

   // Add-3 correction on every digit, then one left shift of {bcd, bin}.
   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
      {shift_out, bcd_sh, bin_sh} = {adj, bin_q, 1'b0};
   end

   always_comb begin
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      res_bcd_d = res_bcd_q;
      res_neg_d = res_neg_q;
      res_ovf_d = res_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               bin_d = mag;
               bcd_d = '0;
               ovf_d = 1'b0;
               neg_d = is_neg;
               cnt_d = '0;
            end
         end
         S_CONV: begin
            if (cnt_q != CNT_LAST) begin
               bin_d = bin_sh;
               bcd_d = bcd_sh;
               ovf_d = ovf_q | shift_out;
               cnt_d = cnt_q + CW'(1);
            end else begin
               res_bcd_d = ovf_q ? ALL_NINE : bcd_q;
               res_neg_d = neg_q;
               res_ovf_d = ovf_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         res_bcd_q <= '0;
         res_neg_q <= 1'b0;
         res_ovf_q <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         neg_q     <= neg_d;
         cnt_q     <= cnt_d;
         res_bcd_q <= res_bcd_d;
         res_neg_q <= res_neg_d;
         res_ovf_q <= res_ovf_d;
      end
   end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: four parameterisations checked against a decimal
// arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_bin2bcd;

   localparam int W_T [4] = '{8, 8, 8, 16};
   localparam int N_T [4] = '{3, 2, 3, 5};
   localparam int S_T [4] = '{0, 0, 1, 0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [15:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        rdy_0, rdy_1, rdy_2, rdy_3;
   logic        vld_0, vld_1, vld_2, vld_3;
   logic        neg_0, neg_1, neg_2, neg_3;
   logic        ovf_0, ovf_1, ovf_2, ovf_3;
   logic [1:0]  dbg_0, dbg_1, dbg_2, dbg_3;
   logic [11:0] bcd_0;
   logic [7:0]  bcd_1;
   logic [11:0] bcd_2;
   logic [19:0] bcd_3;

   int          sel = 0;
   logic        s_ready, s_valid, s_neg, s_ovf;
   logic [19:0] s_bcd;
   logic [1:0]  s_dbg;
   logic [21:0] got;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [21:0] exp_q[$];

   always #5 clk = ~clk;

   seq_bin2bcd #(.W_IN(8), .N_DIGITS(3), .SIGNED(0)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy_0), .in_data(in_data[7:0]),
      .out_valid(vld_0), .out_ready(out_ready), .out_bcd(bcd_0), .out_neg(neg_0),
      .out_overflow(ovf_0), .dbg_state(dbg_0));
   seq_bin2bcd #(.W_IN(8), .N_DIGITS(2), .SIGNED(0)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy_1), .in_data(in_data[7:0]),
      .out_valid(vld_1), .out_ready(out_ready), .out_bcd(bcd_1), .out_neg(neg_1),
      .out_overflow(ovf_1), .dbg_state(dbg_1));
   seq_bin2bcd #(.W_IN(8), .N_DIGITS(3), .SIGNED(1)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy_2), .in_data(in_data[7:0]),
      .out_valid(vld_2), .out_ready(out_ready), .out_bcd(bcd_2), .out_neg(neg_2),
      .out_overflow(ovf_2), .dbg_state(dbg_2));
   seq_bin2bcd #(.W_IN(16), .N_DIGITS(5), .SIGNED(0)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(rdy_3), .in_data(in_data),
      .out_valid(vld_3), .out_ready(out_ready), .out_bcd(bcd_3), .out_neg(neg_3),
      .out_overflow(ovf_3), .dbg_state(dbg_3));

   always_comb begin
      s_ready = 1'b0; s_valid = 1'b0; s_bcd = '0; s_neg = 1'b0; s_ovf = 1'b0; s_dbg = '0;
      case (sel)
         0: begin s_ready = rdy_0; s_valid = vld_0; s_bcd = {8'h0, bcd_0};  s_neg = neg_0; s_ovf = ovf_0; s_dbg = dbg_0; end
         1: begin s_ready = rdy_1; s_valid = vld_1; s_bcd = {12'h0, bcd_1}; s_neg = neg_1; s_ovf = ovf_1; s_dbg = dbg_1; end
         2: begin s_ready = rdy_2; s_valid = vld_2; s_bcd = {8'h0, bcd_2};  s_neg = neg_2; s_ovf = ovf_2; s_dbg = dbg_2; end
         3: begin s_ready = rdy_3; s_valid = vld_3; s_bcd = bcd_3;          s_neg = neg_3; s_ovf = ovf_3; s_dbg = dbg_3; end
         default: ;
      endcase
      got = {s_ovf, s_neg, s_bcd};
   end

   // Reference: {overflow, negative, bcd} from integer arithmetic on the value.
   function automatic logic [21:0] ref_model(input int s, input logic [15:0] d);
      longint      v, lim;
      logic        neg, ovf;
      logic [19:0] b;
      int          w;
      w   = W_T[s];
      v   = longint'(d) & ((longint'(1) << w) - 1);
      lim = 1;
      neg = 1'b0;
      ovf = 1'b0;
      b   = '0;
      for (int i = 0; i < N_T[s]; i++) lim = lim * 10;
      if (S_T[s] != 0 && v >= (longint'(1) << (w - 1))) begin
         neg = 1'b1;
         v   = (longint'(1) << w) - v;
      end
      if (v > lim - 1) begin
         ovf = 1'b1;
         v   = lim - 1;
      end
      for (int i = 0; i < N_T[s]; i++) begin
         b[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return {ovf, neg, b};
   endfunction

   task automatic send(input logic [15:0] d);
      int k = 0;
      @(negedge clk);
      while (!s_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: in_ready=%0b required 1", s_ready);
      end
      in_valid[sel] = 1'b1;
      in_data       = d;
      @(posedge clk);
      #1 in_valid[sel] = 1'b0;
   endtask

   // Called just after the accept edge; returns edges until out_valid is seen.
   task automatic wait_done(output int lat);
      int k = 0;
      lat = -1;
      while (k < 60) begin
         @(negedge clk);
         if (s_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         k++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready[%0d]: got %0b required 0", s, s_ready); end
         n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid[%0d]: got %0b required 0", s, s_valid); end
         n_checks++; if (got !== 22'h0) begin n_fail++; $display("FAIL rst_outs[%0d]: got %h required 0", s, got); end
         n_checks++; if (s_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state[%0d]: got %0d required 0", s, s_dbg); end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready[%0d]: got %0b required 1", s, s_ready); end
      end
   endtask

   task automatic test_conversions(input int s, input int n_rand, input logic [15:0] d0,
                                   input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
                                   input int n_fixed);
      logic [15:0] vals[$];
      logic [21:0] e;
      int          lat;
      sel = s;
      vals = '{d0, d1, d2, d3};
      vals = vals[0 : n_fixed - 1];
      for (int i = 0; i < n_rand; i++) vals.push_back(16'($urandom_range(0, (1 << W_T[s]) - 1)));
      foreach (vals[i]) begin
         exp_q.push_back(ref_model(s, vals[i]));
         send(vals[i]);
         wait_done(lat);
         e = exp_q.pop_front();
         n_checks++; if (lat !== W_T[s] + 1) begin n_fail++; $display("FAIL latency[%0d] in=%0d: got %0d required %0d", s, vals[i], lat, W_T[s] + 1); end
         n_checks++; if (got !== e) begin n_fail++; $display("FAIL result[%0d] in=%0d: got ovf/neg/bcd %h required %h", s, vals[i], got, e); end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      logic [21:0] snap, e;
      int          lat;
      sel = 0;
      send(16'd200);
      wait_done(lat);
      snap = got;
      n_checks++; if (snap !== ref_model(0, 16'd200)) begin n_fail++; $display("FAIL bp_first: got %h required %h", snap, ref_model(0, 16'd200)); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++; if (s_valid !== 1'b1 || s_ready !== 1'b0 || got !== snap) begin
            n_fail++; $display("FAIL bp_hold cyc%0d: valid=%0b ready=%0b outs=%h required 1/0/%h", i, s_valid, s_ready, got, snap);
         end
         in_valid[0] = (i % 2 == 0);
         in_data     = 16'd123;
      end
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data     = 16'd123;
      out_ready   = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (s_valid !== 1'b0 || s_ready !== 1'b1 || got !== snap) begin
         n_fail++; $display("FAIL bp_release: valid=%0b ready=%0b outs=%h required 0/1/%h", s_valid, s_ready, got, snap);
      end
      exp_q.push_back(ref_model(0, 16'd123));
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      wait_done(lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL bp_latency: got %0d required 9", lat); end
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL bp_next: got %h required %h", got, e); end
      release_out();
   endtask

   task automatic test_reset_mid_conv();
      logic [21:0] e;
      int          lat;
      sel = 0;
      send(16'd255);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (s_valid !== 1'b0 || s_dbg !== 2'd0 || got !== 22'h0) begin
         n_fail++; $display("FAIL midrst_abort: valid=%0b state=%0d outs=%h required 0/0/0", s_valid, s_dbg, got);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_release: ready=%0b valid=%0b required 1/0", s_ready, s_valid);
      end
      exp_q.push_back(ref_model(0, 16'd37));
      send(16'd37);
      wait_done(lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL midrst_latency: got %0d required 9", lat); end
      n_checks++; if (got !== e || e[11:0] !== 12'h037) begin n_fail++; $display("FAIL midrst_result: got %h required %h", got, e); end
      release_out();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_conversions(0, 10, 16'd255, 16'd0, 16'd9, 16'd0, 3);
      test_conversions(1, 8, 16'd99, 16'd100, 16'd200, 16'd0, 3);
      test_conversions(2, 10, 16'h80, 16'hFF, 16'h7F, 16'h19, 4);
      test_conversions(3, 6, 16'd65535, 16'd10000, 16'd0, 16'd0, 2);
      test_backpressure();
      test_reset_mid_conv();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
